// File: rtl/alu_seq_decoder_pkg.sv
// Shared ALU control codes, FSM states and funct7 encodings for the ALU sequencing decoder.
package alu_seq_pkg;

  localparam int CODE_W = 5;

  typedef enum logic [CODE_W-1:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_SLL    = 5'h02,
    ALU_SLT    = 5'h03,
    ALU_SLTU   = 5'h04,
    ALU_XOR    = 5'h05,
    ALU_SRA    = 5'h06,
    ALU_SRL    = 5'h07,
    ALU_OR     = 5'h08,
    ALU_AND    = 5'h09,
    ALU_BEQ    = 5'h0A,
    ALU_BNE    = 5'h0B,
    ALU_BGE    = 5'h0C,
    ALU_BGEU   = 5'h0D,
    ALU_MUL    = 5'h10,
    ALU_MULH   = 5'h11,
    ALU_MULHSU = 5'h12,
    ALU_MULHU  = 5'h13,
    ALU_DIV    = 5'h14,
    ALU_DIVU   = 5'h15,
    ALU_REM    = 5'h16,
    ALU_REMU   = 5'h17
  } aluctrl_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/alu_seq_decoder_op_decode.sv
// Combinational funct3/funct7/class-flag decode into an ALU control code.
// RV32M decode is present only when ALU_SEQ_DECODER_MEXT_EN is defined.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       instr_5,
  input  logic       isBranch,
  input  logic       isALUreg,
  input  logic       isALUimm,
  input  logic       isAUIPC,
  input  logic       isJAL,
  output aluctrl_e   code,
  output logic       isShamt,
  output logic       illegal
`ifdef ALU_SEQ_DECODER_MEXT_EN
  ,
  output logic       isMulDiv,
  output logic       isDiv
`endif
);

  aluctrl_e arithCode;
  logic     shiftF3;

  assign shiftF3 = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign isShamt = (isALUreg || isALUimm) && shiftF3;

  always_comb begin
    arithCode = ALU_ADD;
    case (funct3)
      3'b000:  arithCode = (isALUreg && funct7[5] && instr_5) ? ALU_SUB : ALU_ADD;
      3'b001:  arithCode = ALU_SLL;
      3'b010:  arithCode = ALU_SLT;
      3'b011:  arithCode = ALU_SLTU;
      3'b100:  arithCode = ALU_XOR;
      3'b101:  arithCode = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arithCode = ALU_OR;
      default: arithCode = ALU_AND;
    endcase
  end

  // AUIPC/JAL take priority and always resolve to a plain add
  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
`ifdef ALU_SEQ_DECODER_MEXT_EN
    isMulDiv = 1'b0;
    isDiv    = 1'b0;
`endif
    if (isAUIPC || isJAL) begin
      code = ALU_ADD;
    end else if (isALUreg) begin
      if (funct7 == F7_MEXT) begin
`ifdef ALU_SEQ_DECODER_MEXT_EN
        code     = aluctrl_e'({2'b10, funct3});
        isMulDiv = 1'b1;
        isDiv    = funct3[2];
`else
        illegal = 1'b1;
`endif
      end else if ((funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
        code = arithCode;
      end else begin
        illegal = 1'b1;
      end
    end else if (isALUimm) begin
      if (((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
          ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))) begin
        illegal = 1'b1;
      end else begin
        code = arithCode;
      end
    end else if (isBranch) begin
      case (funct3)
        3'b000:  code = ALU_BEQ;
        3'b001:  code = ALU_BNE;
        3'b100:  code = ALU_SLT;
        3'b101:  code = ALU_BGE;
        3'b110:  code = ALU_SLTU;
        3'b111:  code = ALU_BGEU;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_decoder.sv
// Registered ALU decoder with valid/ready handshake and multi-cycle MUL/DIV occupancy.
// Define ALU_SEQ_DECODER_MEXT_EN to enable RV32M decode and the BUSY sequencing.
module alu_seq_decoder
  import alu_seq_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              instr_5,
  input  logic              isBranch,
  input  logic              isALUreg,
  input  logic              isALUimm,
  input  logic              isAUIPC,
  input  logic              isJAL,
  input  logic              flush,
  output logic              outValid,
  output logic [CTRL_W-1:0] aluControl,
  output logic              isShamt,
  output logic              isMulDiv,
  output logic              busy,
  output logic              illegalInstr
);

  if (CTRL_W < CODE_W || MUL_LAT < 1 || DIV_LAT < 1) begin : gBadParam
    $error("alu_seq_decoder: CTRL_W must be >= 5 and latencies >= 1");
  end

  aluctrl_e decCode;
  logic     decShamt;
  logic     decIllegal;
  logic     accept;

  state_e   state_q, state_d;
  aluctrl_e aluCtrl_q, aluCtrl_d;
  logic     outValid_q, outValid_d;
  logic     isShamt_q, isShamt_d;
  logic     illegal_q, illegal_d;

`ifdef ALU_SEQ_DECODER_MEXT_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam bit MUL_MULTI = (MUL_LAT > 1);
  localparam bit DIV_MULTI = (DIV_LAT > 1);

  logic             decMulDiv;
  logic             decIsDiv;
  logic             isMulDiv_q, isMulDiv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  alu_op_decode uDecode (
    .funct3   (funct3),
    .funct7   (funct7),
    .instr_5  (instr_5),
    .isBranch (isBranch),
    .isALUreg (isALUreg),
    .isALUimm (isALUimm),
    .isAUIPC  (isAUIPC),
    .isJAL    (isJAL),
    .code     (decCode),
    .isShamt  (decShamt),
    .illegal  (decIllegal)
`ifdef ALU_SEQ_DECODER_MEXT_EN
    ,
    .isMulDiv (decMulDiv),
    .isDiv    (decIsDiv)
`endif
  );

  assign inReady = (state_q == IDLE);
  assign accept  = inValid && inReady && !flush;

  // Decode results are captured only on accept and then held, so the code
  // stays stable through BUSY and after the completion pulse.
  always_comb begin
    state_d    = state_q;
    aluCtrl_d  = aluCtrl_q;
    isShamt_d  = isShamt_q;
    illegal_d  = illegal_q;
    outValid_d = 1'b0;
`ifdef ALU_SEQ_DECODER_MEXT_EN
    isMulDiv_d = isMulDiv_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          aluCtrl_d = decIllegal ? ALU_ADD : decCode;
          isShamt_d = decShamt;
          illegal_d = decIllegal;
`ifdef ALU_SEQ_DECODER_MEXT_EN
          isMulDiv_d = decMulDiv;
          if (decMulDiv && (decIsDiv ? DIV_MULTI : MUL_MULTI)) begin
            state_d = BUSY;
            cnt_d   = decIsDiv ? DIV_CNT : MUL_CNT;
          end else begin
            outValid_d = 1'b1;
          end
`else
          outValid_d = 1'b1;
`endif
        end
      end
`ifdef ALU_SEQ_DECODER_MEXT_EN
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d    = IDLE;
          outValid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      aluCtrl_q  <= ALU_ADD;
      isShamt_q  <= 1'b0;
      illegal_q  <= 1'b0;
      outValid_q <= 1'b0;
`ifdef ALU_SEQ_DECODER_MEXT_EN
      isMulDiv_q <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      aluCtrl_q  <= aluCtrl_d;
      isShamt_q  <= isShamt_d;
      illegal_q  <= illegal_d;
      outValid_q <= outValid_d;
`ifdef ALU_SEQ_DECODER_MEXT_EN
      isMulDiv_q <= isMulDiv_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign outValid     = outValid_q;
  assign aluControl   = CTRL_W'(aluCtrl_q);
  assign isShamt      = isShamt_q;
  assign illegalInstr = illegal_q;
`ifdef ALU_SEQ_DECODER_MEXT_EN
  assign isMulDiv = isMulDiv_q;
  assign busy     = (state_q == BUSY);
`else
  assign isMulDiv = 1'b0;
  assign busy     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_decoder.sv
// Directed self-checking bench for alu_seq_decoder with default parameters;
// the RV32M section follows ALU_SEQ_DECODER_MEXT_EN.
module tb_alu_seq_decoder;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       instr_5;
  logic       isBranch;
  logic       isALUreg;
  logic       isALUimm;
  logic       isAUIPC;
  logic       isJAL;
  logic       flush;
  logic       outValid;
  logic [4:0] aluControl;
  logic       isShamt;
  logic       isMulDiv;
  logic       busy;
  logic       illegalInstr;

  int testsRun;
  int testsFailed;
  int pulseCount;

  localparam logic [2:0] CLS_REG = 3'd0;
  localparam logic [2:0] CLS_IMM = 3'd1;
  localparam logic [2:0] CLS_BR  = 3'd2;
  localparam logic [2:0] CLS_AUI = 3'd3;
  localparam logic [2:0] CLS_JAL = 3'd4;

  alu_seq_decoder #(.CTRL_W(5), .MUL_LAT(2), .DIV_LAT(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .funct3       (funct3),
    .funct7       (funct7),
    .instr_5      (instr_5),
    .isBranch     (isBranch),
    .isALUreg     (isALUreg),
    .isALUimm     (isALUimm),
    .isAUIPC      (isAUIPC),
    .isJAL        (isJAL),
    .flush        (flush),
    .outValid     (outValid),
    .aluControl   (aluControl),
    .isShamt      (isShamt),
    .isMulDiv     (isMulDiv),
    .busy         (busy),
    .illegalInstr (illegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] cls, input logic [2:0] f3,
                               input logic [6:0] f7, input logic i5,
                               input logic valid, input logic fl);
    isALUreg = (cls == CLS_REG);
    isALUimm = (cls == CLS_IMM);
    isBranch = (cls == CLS_BR);
    isAUIPC  = (cls == CLS_AUI);
    isJAL    = (cls == CLS_JAL);
    funct3   = f3;
    funct7   = f7;
    instr_5  = i5;
    inValid  = valid;
    flush    = fl;
  endtask

  task automatic idle();
    applyStimulus(CLS_REG, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDecode(input string tag, input logic [4:0] code,
                             input logic shamt, input logic ill);
    checkOutput({tag, ".outValid"}, 32'(outValid), 32'd1);
    checkOutput({tag, ".aluControl"}, 32'(aluControl), 32'(code));
    checkOutput({tag, ".isShamt"}, 32'(isShamt), 32'(shamt));
    checkOutput({tag, ".illegal"}, 32'(illegalInstr), 32'(ill));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("rst.outValid", 32'(outValid), 32'd0);
    checkOutput("rst.aluControl", 32'(aluControl), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.inReady", 32'(inReady), 32'd1);
    checkOutput("rst.isMulDiv", 32'(isMulDiv), 32'd0);
    checkOutput("rst.illegal", 32'(illegalInstr), 32'd0);
    checkOutput("rst.isShamt", 32'(isShamt), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postRst.outValid", 32'(outValid), 32'd0);

    // Back-to-back single-cycle decodes, one accept per cycle
    applyStimulus(CLS_REG, 3'b000, 7'b0100000, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("sub", 5'h01, 1'b0, 1'b0);
    applyStimulus(CLS_IMM, 3'b101, 7'b0100000, 1'b0, 1'b1, 1'b0); tick();
    checkDecode("srai", 5'h06, 1'b1, 1'b0);
    applyStimulus(CLS_BR, 3'b111, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("bgeu", 5'h0D, 1'b0, 1'b0);
    applyStimulus(CLS_BR, 3'b010, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("br010", 5'h00, 1'b0, 1'b1);
    applyStimulus(CLS_REG, 3'b101, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("srl", 5'h07, 1'b1, 1'b0);
    applyStimulus(CLS_REG, 3'b111, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("and", 5'h09, 1'b0, 1'b0);
    applyStimulus(CLS_REG, 3'b001, 7'b0100000, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("regAltBad", 5'h00, 1'b1, 1'b1);
    applyStimulus(CLS_IMM, 3'b001, 7'b0000010, 1'b0, 1'b1, 1'b0); tick();
    checkDecode("slliBad", 5'h00, 1'b1, 1'b1);
    applyStimulus(CLS_IMM, 3'b000, 7'b0100000, 1'b0, 1'b1, 1'b0); tick();
    checkDecode("addiNotSub", 5'h00, 1'b0, 1'b0);
    applyStimulus(CLS_IMM, 3'b110, 7'h7F, 1'b0, 1'b1, 1'b0); tick();
    checkDecode("ori", 5'h08, 1'b0, 1'b0);
    applyStimulus(CLS_BR, 3'b100, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("blt", 5'h03, 1'b0, 1'b0);
    applyStimulus(CLS_BR, 3'b110, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("bltu", 5'h04, 1'b0, 1'b0);
    applyStimulus(CLS_BR, 3'b001, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("bne", 5'h0B, 1'b0, 1'b0);
    applyStimulus(CLS_BR, 3'b101, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("bge", 5'h0C, 1'b0, 1'b0);
    applyStimulus(CLS_REG, 3'b100, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("xor", 5'h05, 1'b0, 1'b0);
    applyStimulus(CLS_AUI, 3'b111, 7'h20, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("auipc", 5'h00, 1'b0, 1'b0);
    applyStimulus(CLS_REG, 3'b011, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("sltu", 5'h04, 1'b0, 1'b0);

    // Idle cycle: pulse drops, code holds
    idle(); tick();
    checkOutput("idle.outValid", 32'(outValid), 32'd0);
    checkOutput("idle.hold", 32'(aluControl), 32'h04);

    // Flush alongside a request in IDLE drops the request
    applyStimulus(CLS_REG, 3'b000, 7'b0100000, 1'b1, 1'b1, 1'b1); tick();
    checkOutput("flushIdle.outValid", 32'(outValid), 32'd0);
    checkOutput("flushIdle.hold", 32'(aluControl), 32'h04);
    idle(); tick();

`ifdef ALU_SEQ_DECODER_MEXT_EN
    // DIV: busy for 31 cycles, completion pulse on the 32nd
    applyStimulus(CLS_REG, 3'b100, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    idle();
    checkOutput("div.aluControl", 32'(aluControl), 32'h14);
    checkOutput("div.isMulDiv", 32'(isMulDiv), 32'd1);
    pulseCount = 0;
    for (int i = 0; i < 31; i++) begin
      if (busy !== 1'b1 || inReady !== 1'b0 || outValid !== 1'b0 || aluControl !== 5'h14)
        pulseCount++;
      if (i < 30) tick();
    end
    checkOutput("div.busyWindow", 32'(pulseCount), 32'd0);
    tick();
    checkOutput("div.outValid", 32'(outValid), 32'd1);
    checkOutput("div.busyDone", 32'(busy), 32'd0);
    checkOutput("div.inReady", 32'(inReady), 32'd1);
    checkOutput("div.holdCode", 32'(aluControl), 32'h14);
    tick();
    checkOutput("div.pulseOnce", 32'(outValid), 32'd0);

    // MUL followed by an ADD held on inValid
    applyStimulus(CLS_REG, 3'b000, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("mul.busy", 32'(busy), 32'd1);
    checkOutput("mul.code", 32'(aluControl), 32'h10);
    checkOutput("mul.noValid", 32'(outValid), 32'd0);
    applyStimulus(CLS_REG, 3'b000, 7'h00, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("mul.outValid", 32'(outValid), 32'd1);
    checkOutput("mul.codeDone", 32'(aluControl), 32'h10);
    checkOutput("mul.inReady", 32'(inReady), 32'd1);
    tick();
    checkOutput("add.outValid", 32'(outValid), 32'd1);
    checkOutput("add.code", 32'(aluControl), 32'h00);
    checkOutput("add.isMulDiv", 32'(isMulDiv), 32'd0);
    idle(); tick();
    checkOutput("add.pulseOnce", 32'(outValid), 32'd0);

    // DIV aborted by flush at cycle 10
    applyStimulus(CLS_REG, 3'b101, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    idle();
    for (int i = 0; i < 9; i++) tick();
    checkOutput("flush.busyBefore", 32'(busy), 32'd1);
    applyStimulus(CLS_REG, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1); tick();
    idle();
    checkOutput("flush.busy", 32'(busy), 32'd0);
    checkOutput("flush.outValid", 32'(outValid), 32'd0);
    checkOutput("flush.inReady", 32'(inReady), 32'd1);
    pulseCount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (outValid !== 1'b0) pulseCount++;
    end
    checkOutput("flush.noLatePulse", 32'(pulseCount), 32'd0);

    // Asynchronous reset in the middle of a DIV
    applyStimulus(CLS_REG, 3'b110, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rstMid.busyBefore", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMid.busy", 32'(busy), 32'd0);
    checkOutput("rstMid.aluControl", 32'(aluControl), 32'd0);
    checkOutput("rstMid.isMulDiv", 32'(isMulDiv), 32'd0);
    checkOutput("rstMid.inReady", 32'(inReady), 32'd1);
    tick();
    reset = 1'b0;
    pulseCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (outValid !== 1'b0) pulseCount++;
    end
    checkOutput("rstMid.noLatePulse", 32'(pulseCount), 32'd0);
`else
    // Without RV32M, funct7=0000001 on ALUreg is illegal and single-cycle
    applyStimulus(CLS_REG, 3'b000, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("mulOff", 5'h00, 1'b0, 1'b1);
    checkOutput("mulOff.busy", 32'(busy), 32'd0);
    checkOutput("mulOff.isMulDiv", 32'(isMulDiv), 32'd0);
    checkOutput("mulOff.inReady", 32'(inReady), 32'd1);
    applyStimulus(CLS_REG, 3'b100, 7'b0000001, 1'b1, 1'b1, 1'b0); tick();
    checkDecode("divOff", 5'h00, 1'b0, 1'b1);
    checkOutput("divOff.busy", 32'(busy), 32'd0);

    // Asynchronous reset clears registered outputs between edges
    applyStimulus(CLS_REG, 3'b000, 7'b0100000, 1'b1, 1'b1, 1'b0); tick();
    idle();
    checkOutput("rstMid.before", 32'(aluControl), 32'h01);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMid.aluControl", 32'(aluControl), 32'd0);
    checkOutput("rstMid.outValid", 32'(outValid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rstMid.after", 32'(outValid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_seq_decoder.md
Name: alu_seq_decoder

Overview:
Parametrised, registered successor to the single-cycle ALU decoder for the RISC-V core. It decodes funct3/funct7 and the instruction-class flags into a CTRL_W-bit ALU control code, adding RV32M decode.
- Sequences multi-cycle MUL/DIV occupancy with an FSM and down-counter.
- Exposes a valid/ready handshake so the core stalls while a long op is in flight.
- Sits between the main decoder and the ALU/muldiv datapath.

Parameters:
CTRL_W, 5, width of aluControl (must be >=5 for M codes)
MUL_LAT, 2, cycles from accept to outValid for MUL* (>=1)
DIV_LAT, 32, cycles from accept to outValid for DIV*/REM* (>=1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
inValid  in  1  decode request valid
inReady  out  1  block can accept; equals (state==IDLE)
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
instr_5  in  1  instruction bit 5 (reg vs imm form)
isBranch, isALUreg, isALUimm, isAUIPC, isJAL  in  1 each  class flags from main decoder
flush  in  1  abort any in-flight op, drop pending output
outValid  out  1  one-cycle pulse: outputs below are valid
aluControl  out  CTRL_W  registered ALU op code
isShamt  out  1  registered: shift uses shamt/imm
isMulDiv  out  1  registered: op is RV32M
busy  out  1  multi-cycle op in progress
illegalInstr  out  1  registered: undecodable combination

Behaviour:
- Codes: ADD 0, SUB 1, SLL 2, SLT/BLT 3, SLTU/BLTU 4, XOR 5, SRA 6, SRL 7, OR 8, AND 9, BEQ A, BNE B, BGE C, BGEU D.
- M codes: MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17 (hex).
- Base decode:
  - SUB only when isALUreg & funct7[5] & instr_5 & funct3==000.
  - SRA when funct3==101 & funct7[5].
  - isShamt=1 for (isALUreg|isALUimm) & funct3 in {001,101}.
  - AUIPC, JAL and all other classes give ADD.
- M decode: isALUreg & funct7==0000001 gives code 10+funct3 and isMulDiv=1. funct3[2]=0 selects MUL_LAT, funct3[2]=1 selects DIV_LAT.
- illegalInstr=1 (and aluControl=ADD) for any of:
  - isBranch & funct3 in {010,011}.
  - isALUreg & funct7 not in {0000000, 0100000 (f3 000/101 only), 0000001}.
  - isALUimm & funct3==001 & funct7!=0.
  - isALUimm & funct3==101 & funct7 not in {0000000, 0100000}.
- FSM states IDLE, BUSY. Accept = inValid & inReady & !flush.
- IDLE + accept, single-cycle op (or M op with LAT==1): outputs registered; outValid=1 next cycle (latency 1); stay IDLE.
- IDLE + accept, M op with LAT>1:
  - aluControl/isMulDiv registered next cycle; go BUSY; cnt=LAT-2; busy=1.
  - In BUSY, cnt decrements each cycle. When cnt==0, outValid=1 that cycle's next edge, busy drops, return IDLE.
  - Total accept-to-outValid = LAT cycles.
- aluControl stays stable for the whole BUSY period and holds its last value after outValid.
- flush: BUSY goes to IDLE next edge, no outValid, busy=0. Flush with inValid in IDLE: request ignored, outValid=0.
- outValid pulses one cycle only; no backpressure on the output side.
- Back-to-back single-cycle ops: one accept per cycle, outValid continuous.
- Reset (any time, including mid-BUSY): state IDLE, cnt=0, outValid=0, aluControl=0, isShamt=0, isMulDiv=0, busy=0, illegalInstr=0.
- Counter width $clog2(max(MUL_LAT,DIV_LAT)+1).

Optional Feature:
ALU_SEQ_DECODER_MEXT_EN.
- Defined: RV32M decode and BUSY sequencing as above.
- Undefined: funct7==0000001 on ALUreg sets illegalInstr=1 with aluControl=ADD and latency 1. BUSY is unreachable, busy is tied 0, isMulDiv is tied 0, and the counter is removed.

Decomposition:
- Package alu_seq_pkg holds:
  - enum aluctrl_e with all codes above.
  - state_e {IDLE, BUSY}.
  - localparams F7_BASE=0000000, F7_ALT=0100000, F7_MEXT=0000001.
- Sub-module alu_op_decode: purely combinational funct/flags to {code, isShamt, isMulDiv, illegal, isDiv}.
- Top module holds registers, FSM and counter.

Test Plan:
1. ALUreg f3=000 f7=0100000 instr_5=1 inValid=1 -> next cycle outValid=1, aluControl=1 (SUB), isShamt=0.
2. ALUimm f3=101 f7=0100000 -> aluControl=6, isShamt=1. Branch f3=111 -> aluControl=D. Branch f3=010 -> illegalInstr=1, aluControl=0.
3. MEXT_EN, DIV_LAT=32: ALUreg f7=0000001 f3=100 -> aluControl=14, busy=1, inReady=0 for 31 cycles; outValid on cycle 32 after accept; inReady=1 after.
4. MUL (f3=000, MUL_LAT=2) followed by ADD held on inValid -> MUL outValid at cycle 2, ADD accepted the cycle inReady returns, ADD outValid next cycle.
5. DIV in flight, flush at cycle 10 -> no outValid, busy=0 next cycle. Repeat with reset asserted mid-BUSY -> all outputs 0 immediately (asynchronous).
6. MEXT_EN undefined: f7=0000001 ALUreg -> illegalInstr=1, aluControl=0, busy stays 0, latency 1.
